// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, sync polarity and colour-bar palette
// for the VGA raster generator.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam logic VGA_SYNC_ACTIVE = 1'b0;

    localparam int NUM_BARS = 8;
    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bits_t;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Parameterised width/depth shift line with synchronous clear to a
// configurable idle value; keeps sync/blank aligned with renderer latency.
module vga_sync_delay #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] w_tap [DEPTH+1];

    assign w_tap[0] = i_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge clk) begin
                if (srst) begin
                    r_q <= CLEAR_VALUE;
                end else begin
                    r_q <= w_tap[gi];
                end
            end

            assign w_tap[gi+1] = r_q;
        end
    endgenerate

    assign o_q = w_tap[DEPTH];

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster counters plus sync/blank re-alignment with the renderer's RGB.
// Optional built-in colour bars when VGA_TEST_PATTERN_EN is defined.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   H_FP        = VGA_H_FP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BP        = VGA_H_BP,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   V_FP        = VGA_V_FP,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BP        = VGA_V_BP,
    parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE,
    parameter int   PIPE_DELAY  = 1
) (
    input  logic        VGA_clk,
    input  logic        rst,
    output logic [15:0] X,
    output logic [15:0] Y,
    output logic        display_on,
    output logic        frame_tick,
    input  logic [23:0] RGB,
    input  logic        test_mode,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic       SYNC_IDLE  = ~SYNC_ACTIVE;
    localparam sync_bits_t SYNC_CLEAR = '{hs: SYNC_IDLE, vs: SYNC_IDLE, de: 1'b0};

    logic [15:0] r_x;
    logic [15:0] r_y;
    sync_bits_t  w_raw;
    sync_bits_t  w_dly;
    logic [23:0] w_color;
    logic [23:0] r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;

    always_ff @(posedge VGA_clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_x == H_LAST) begin
            r_x <= '0;
            r_y <= (r_y == V_LAST) ? 16'd0 : r_y + 16'd1;
        end else begin
            r_x <= r_x + 16'd1;
        end
    end

    assign X          = r_x;
    assign Y          = r_y;
    assign display_on = (r_x < H_ACT) && (r_y < V_ACT);
    assign frame_tick = (r_x == 16'd0) && (r_y == V_ACT);

    always_comb begin
        w_raw    = SYNC_CLEAR;
        w_raw.hs = (r_x >= HS_START && r_x < HS_END) ? SYNC_ACTIVE : SYNC_IDLE;
        w_raw.vs = (r_y >= VS_START && r_y < VS_END) ? SYNC_ACTIVE : SYNC_IDLE;
        w_raw.de = display_on;
    end

    // Match the renderer's X/Y -> RGB latency so sync, blank and colour coincide.
    vga_sync_delay #(
        .WIDTH      ($bits(sync_bits_t)),
        .DEPTH      (PIPE_DELAY),
        .CLEAR_VALUE(SYNC_CLEAR)
    ) u_sync_delay (
        .clk (VGA_clk),
        .srst(rst),
        .i_d (w_raw),
        .o_q (w_dly)
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [15:0] BAR_W = 16'(H_ACTIVE / NUM_BARS);

    logic [15:0] w_bar_quot;
    logic [2:0]  w_bar_idx;
    logic [2:0]  w_bar_idx_dly;

    assign w_bar_quot = r_x / BAR_W;
    assign w_bar_idx  = (w_bar_quot >= 16'(NUM_BARS)) ? 3'(NUM_BARS - 1) : w_bar_quot[2:0];

    vga_sync_delay #(
        .WIDTH      (3),
        .DEPTH      (PIPE_DELAY),
        .CLEAR_VALUE(3'd0)
    ) u_bar_delay (
        .clk (VGA_clk),
        .srst(rst),
        .i_d (w_bar_idx),
        .o_q (w_bar_idx_dly)
    );

    assign w_color = test_mode ? bar_color(w_bar_idx_dly) : RGB;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;
    assign w_color            = RGB;
`endif

    always_ff @(posedge VGA_clk) begin
        if (rst) begin
            r_rgb     <= '0;
            r_hs      <= SYNC_IDLE;
            r_vs      <= SYNC_IDLE;
            r_blank_n <= 1'b0;
        end else begin
            r_rgb     <= w_dly.de ? w_color : 24'd0;
            r_hs      <= w_dly.hs;
            r_vs      <= w_dly.vs;
            r_blank_n <= w_dly.de;
        end
    end

    assign VGA_R       = r_rgb[23:16];
    assign VGA_G       = r_rgb[15:8];
    assign VGA_B       = r_rgb[7:0];
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Randomised scoreboard bench for vga_timing_controller on a reduced raster;
// the reference model derives every pixel from its absolute frame position.
module tb_vga_timing_controller;

    localparam int HA = 64, HF = 4, HSW = 8, HB = 4;
    localparam int VA = 16, VF = 2, VSW = 2, VB = 3;
    localparam int PD = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    logic        VGA_clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] X, Y;
    logic        display_on, frame_tick;
    logic [23:0] RGB = 24'd0;
    logic        test_mode = 1'b0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;

    always #5 VGA_clk = ~VGA_clk;

    vga_timing_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_ACTIVE(1'b0), .PIPE_DELAY(PD)
    ) dut (
        .VGA_clk(VGA_clk), .rst(rst), .X(X), .Y(Y),
        .display_on(display_on), .frame_tick(frame_tick),
        .RGB(RGB), .test_mode(test_mode),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N)
    );

    typedef struct packed { logic [15:0] x; logic [15:0] y; logic de; logic ft; } cnt_exp_t;
    typedef struct packed { logic [23:0] rgb; logic hs; logic vs; logic bn; } vid_exp_t;

    cnt_exp_t q_cnt[$];
    vid_exp_t q_vid[$];
    int n_checks = 0;
    int n_fail = 0;

`ifdef VGA_TEST_PATTERN_EN
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected video for raster position p (-1 = flushed/blank), given the
    // colour and test_mode the DUT sampled on the output edge.
    function automatic vid_exp_t model_out(input int p, input logic [23:0] rgb, input logic tm);
        vid_exp_t e;
        int x, y;
        e.rgb = 24'd0; e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0;
        if (p >= 0) begin
            x = p % HT;
            y = p / HT;
            e.hs = !(x >= HA + HF && x < HA + HF + HSW);
            e.vs = !(y >= VA + VF && y < VA + VF + VSW);
            e.bn = (x < HA) && (y < VA);
            if (e.bn) e.rgb = rgb;
`ifdef VGA_TEST_PATTERN_EN
            if (e.bn && tm) e.rgb = bars[x / (HA / 8)];
`else
            if (tm === 1'bx) e.rgb = 24'd0;
`endif
        end
        return e;
    endfunction

    // Stimulus + model state
    int          pos = 0;
    int          hist[$];
    logic [23:0] rgb_prev = 24'd0;
    logic        tm_prev = 1'b0;
    logic        tm_next = 1'b0;
    logic        rst_was = 1'b1;

    task automatic cycle(input logic do_rst);
        cnt_exp_t c;
        int x, y;
        @(posedge VGA_clk);
        #1;
        if (rst_was) begin
            pos = 0;
            hist.delete();
            for (int i = 0; i <= PD; i++) hist.push_back(-1);
        end else begin
            void'(hist.pop_front());
            hist.push_back(pos);
            pos = (pos + 1) % FRAME;
        end
        x = pos % HT;
        y = pos / HT;
        c.x  = 16'(x);
        c.y  = 16'(y);
        c.de = (x < HA) && (y < VA);
        c.ft = (x == 0) && (y == VA);
        q_cnt.push_back(c);
        q_vid.push_back(model_out(hist[0], rgb_prev, tm_prev));
        rgb_prev  = 24'($urandom);
        RGB       = rgb_prev;
        test_mode = tm_next;
        tm_prev   = tm_next;
        rst       = do_rst;
        rst_was   = do_rst;
    endtask

    // Monitor: pops expectations and compares every cycle, plus run-length checks.
    int   mcyc = 0, last_tick = -1;
    int   hs_run = 0, vs_run = 0;
    bit   hs_ok = 0, vs_ok = 0;
    logic hs_last = 1'b1, vs_last = 1'b1;

    initial begin
        cnt_exp_t c;
        vid_exp_t v;
        forever begin
            @(negedge VGA_clk);
            mcyc++;
            if (q_cnt.size() > 0) begin
                c = q_cnt.pop_front();
                chk("X", 32'(X), 32'(c.x));
                chk("Y", 32'(Y), 32'(c.y));
                chk("display_on", 32'(display_on), 32'(c.de));
                chk("frame_tick", 32'(frame_tick), 32'(c.ft));
            end
            if (q_vid.size() > 0) begin
                v = q_vid.pop_front();
                chk("VGA_RGB", 32'({VGA_R, VGA_G, VGA_B}), 32'(v.rgb));
                chk("VGA_HS", 32'(VGA_HS), 32'(v.hs));
                chk("VGA_VS", 32'(VGA_VS), 32'(v.vs));
                chk("VGA_BLANK_N", 32'(VGA_BLANK_N), 32'(v.bn));
                chk("VGA_SYNC_N", 32'(VGA_SYNC_N), 32'd0);
            end
            if (rst === 1'b1) begin
                last_tick = -1; hs_ok = 0; vs_ok = 0;
            end
            if (frame_tick === 1'b1 && rst !== 1'b1) begin
                if (last_tick >= 0) chk("frame_period", 32'(mcyc - last_tick), 32'(FRAME));
                last_tick = mcyc;
            end
            if (VGA_HS === 1'b0) begin
                if (hs_last !== 1'b0) begin hs_run = 0; hs_ok = (rst !== 1'b1); end
                hs_run++;
            end else if (hs_last === 1'b0 && hs_ok) begin
                chk("hs_width", 32'(hs_run), 32'(HSW));
            end
            if (VGA_VS === 1'b0) begin
                if (vs_last !== 1'b0) begin vs_run = 0; vs_ok = (rst !== 1'b1); end
                vs_run++;
            end else if (vs_last === 1'b0 && vs_ok) begin
                chk("vs_width", 32'(vs_run), 32'(VSW * HT));
            end
            hs_last = VGA_HS;
            vs_last = VGA_VS;
        end
    end

    initial begin
        int target, len;
        repeat (3) @(posedge VGA_clk);
        #1;
        // First call's edge samples the still-asserted reset.
        $display("segment 0: power-on reset, two frames, test_mode=0");
        for (int i = 0; i < 2 * FRAME + 100; i++) cycle(1'b0);

        target = 10 * HT + 30;
        for (int i = 0; i < FRAME && ((pos + 1) % FRAME) != target; i++) cycle(1'b0);
        cycle(1'b1);
        $display("segment 1: reset pulse at X=%0d Y=%0d", pos % HT, pos / HT);
        for (int i = 0; i < FRAME + 50; i++) cycle(1'b0);

        for (int s = 2; s < 6; s++) begin
            tm_next = 1'($urandom_range(0, 1));
            len = $urandom_range(200, 2500);
            $display("segment %0d: test_mode=%0b, %0d cycles then reset at pos %0d",
                     s, tm_next, len, (pos + len) % FRAME);
            for (int i = 0; i < len - 1; i++) cycle(1'b0);
            cycle(1'b1);
        end
        tm_next = 1'b1;
        $display("segment 6: test_mode=1, one frame");
        for (int i = 0; i < FRAME + 10; i++) cycle(1'b0);

        @(negedge VGA_clk);
        @(negedge VGA_clk);
        chk("scoreboard_drained", 32'(q_cnt.size() + q_vid.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Generates the VGA raster for the display path: free-running pixel/line counters drive `X`, `Y` and `display_on` into the image renderer. The renderer's registered `RGB` comes back into this block, which re-aligns sync and blanking with it and drives the VGA DAC pins. Together the two blocks form a closed loop: counters out, colour back in, aligned video out.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `SYNC_ACTIVE`, 0, asserted level of `VGA_HS` and `VGA_VS`
- `PIPE_DELAY`, 1, renderer latency in cycles from `X`/`Y` to `RGB`; must be at least 1

Ports:
- `VGA_clk` in 1: pixel clock (25.175 MHz nominal)
- `rst` in 1: synchronous, active-high reset
- `X` out 16: current pixel column
- `Y` out 16: current line
- `display_on` out 1: high when `X < H_ACTIVE` and `Y < V_ACTIVE`
- `frame_tick` out 1: one-cycle pulse at the start of vertical blanking
- `RGB` in 24: colour from the renderer, {R,G,B}
- `test_mode` in 1: selects the built-in test pattern; ignored unless the macro is defined
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: DAC colour
- `VGA_HS`, `VGA_VS` out 1: sync signals
- `VGA_BLANK_N` out 1: high during active video
- `VGA_SYNC_N` out 1: constant 0

## Operation
- Totals: `H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP` (800); `V_TOTAL` = 525.
- `X` increments every cycle.
  - At `X == H_TOTAL-1`: `X` returns to 0 and `Y` increments.
  - At `Y == V_TOTAL-1` on that same wrap: `Y` returns to 0.
- `X` and `Y` are zero-extended to 16 bits.
- `display_on` is decoded combinationally from the registered `X`/`Y`.
- Raw sync levels:
  - hsync is asserted for `H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC` (656..751).
  - vsync is asserted for `V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC` (490..491).
  - Both use `SYNC_ACTIVE` polarity.
- `frame_tick` is high exactly during the cycle when the counters read `X=0`, `Y=V_ACTIVE`.
- Alignment: raw hsync, vsync and `display_on` pass through a `PIPE_DELAY`-deep shift line. The delayed signals and `RGB` are then registered into the outputs.
- Colour gating: `VGA_R/G/B` carry `RGB` when the delayed `display_on` is 1, otherwise 0. `VGA_BLANK_N` equals the delayed `display_on`.
- Reset values:
  - `X=0`, `Y=0`, so `display_on=1`.
  - `frame_tick=0`.
  - Colour outputs 0, `VGA_BLANK_N=0`.
  - `VGA_HS` and `VGA_VS` at `~SYNC_ACTIVE`.
  - All delay-line stages cleared to blank and sync-inactive.
- Reset mid-frame: counters restart at (0,0) on the next edge and the delay line is flushed. The first PIPE_DELAY+1 output cycles after reset are therefore blank.

## Timing
- Counter, `display_on` and `frame_tick` latency: 0 cycles relative to `X`/`Y`.
- Video output latency: `PIPE_DELAY+1` cycles.
  - The outputs for the pixel at counter value (x,y) appear `PIPE_DELAY+1` edges after `X/Y=(x,y)`.
  - Sync, blank and colour are coincident.
- Line period: `H_TOTAL` cycles. Frame period: `H_TOTAL*V_TOTAL` = 420000 cycles.
- No handshake: `RGB` is sampled unconditionally every cycle. The renderer must meet `PIPE_DELAY` exactly.

## Configuration
Macro: `VGA_TEST_PATTERN_EN`.
- Defined:
  - When `test_mode=1`, `RGB` is replaced by 8 vertical colour bars, each `H_ACTIVE/8` wide.
  - Bar order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - The bar index is computed from `X` and delayed `PIPE_DELAY` cycles so it stays aligned with the sync signals.
- Not defined: the port exists but is ignored; the colour path is `RGB` only.

## Structure
- Shared package `vga_timing_pkg`:
  - 640x480@60 timing constants.
  - Sync polarity constant.
  - The eight bar colour constants.
- Sub-module `vga_sync_delay`: a parameterised width/depth shift register with synchronous clear. It is used for the hsync/vsync/display_on line and for the test-pattern bar index.

## Test plan
- Release reset, run 2 frames -> `X` sweeps 0..799, `Y` 0..524; (799,524) is followed by (0,0); the frame period is 420000 cycles.
- Observe sync outputs -> `VGA_HS` low for exactly 96 cycles, first low 2 cycles after `X=656`; `VGA_VS` low for exactly 1600 cycles, starting at the output for `X=0,Y=490`.
- Hold `RGB=24'h00FF00` -> `VGA_G=FF` only while `VGA_BLANK_N=1`; 307200 such cycles per frame; `VGA_R/G/B=0` during blanking.
- Count `frame_tick` -> exactly one pulse per frame, coincident with `X=0,Y=480`.
- Pulse `rst` for 1 cycle at `X=300,Y=200` -> next cycle `X=0,Y=0`; `VGA_HS/VS=1` and `VGA_BLANK_N=0` for 2 cycles; output then resumes from pixel (0,0).
- With `VGA_TEST_PATTERN_EN` defined and `test_mode=1` -> output pixel 0 = FFFFFF, pixel 80 = FFFF00, pixel 639 = 000000, regardless of `RGB`.
